// File: rtl/fdd_track_sched.sv
// Floppy track-buffer scheduler: keeps one track of sectors cached, writes back dirty
// sectors of the old track over the SD channel, then reads in the newly requested track.
module fdd_track_sched #(
    parameter int SPT       = 13,
    parameter int MAX_TRACK = 34
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [5:0]  track,
    input  logic        img_mounted,
    input  logic        img_size_nz,
    input  logic        img_readonly,
    input  logic        wr_strobe,
    input  logic [3:0]  wr_sec,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [3:0]  buf_sec,
    output logic        cpu_wait,
    output logic        track_valid
);

    typedef enum logic [2:0] {IDLE, FLUSH_REQ, FLUSH_XFER, LOAD_REQ, LOAD_XFER} state_t;

    localparam logic [31:0] SPT_L    = 32'(SPT);
    localparam logic [4:0]  SPT_5    = 5'(SPT);
    localparam logic [3:0]  LAST_SEC = 4'(SPT - 1);
    localparam logic [5:0]  MAX_T    = 6'(MAX_TRACK);

    state_t         state_q, state_d;
    logic [5:0]     cur_track_q, cur_track_d;
    logic [5:0]     load_track_q, load_track_d;
    logic [SPT-1:0] dirty_q, dirty_d;
    logic [3:0]     sec_q, sec_d;
    logic           old_ack_q;
    logic           load_pending_q, load_pending_d;
    logic           track_valid_q, track_valid_d;
    logic           sd_rd_q, sd_rd_d;
    logic           sd_wr_q, sd_wr_d;
    logic           cpu_wait_q, cpu_wait_d;
    logic [31:0]    sd_lba_q, sd_lba_d;
    logic [3:0]     buf_sec_q, buf_sec_d;

    logic           ack_rise, ack_fall, legal, wr_ok, start_load;
    logic [SPT-1:0] set_m, clr_m, dirty_keep, dirty_left;

    function automatic logic [3:0] lowest_set(input logic [SPT-1:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = SPT - 1; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [31:0] lba_of(input logic [5:0] trk, input logic [3:0] s);
        return SPT_L * {26'd0, trk} + {28'd0, s};
    endfunction

    always_comb begin
        ack_rise = sd_ack & ~old_ack_q;
        ack_fall = ~sd_ack & old_ack_q;
        legal    = img_size_nz && (track <= MAX_T);
        wr_ok    = wr_strobe && !img_readonly && ({1'b0, wr_sec} < SPT_5);
        for (int i = 0; i < SPT; i++) begin
            set_m[i] = wr_ok && (wr_sec == 4'(i));
            clr_m[i] = (sec_q == 4'(i));
        end
        // A mount wipes the mask outright; otherwise a fresh write beats the flush clear.
        dirty_keep = img_mounted ? '0 : (dirty_q | set_m);
        dirty_left = img_mounted ? '0 : ((dirty_q & ~clr_m) | set_m);

        state_d        = state_q;
        cur_track_d    = cur_track_q;
        load_track_d   = load_track_q;
        sec_d          = sec_q;
        dirty_d        = dirty_keep;
        load_pending_d = load_pending_q | img_mounted;
        track_valid_d  = track_valid_q & ~img_mounted;
        start_load     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!legal) begin
                    track_valid_d = 1'b0;
                end else if ((track != cur_track_q) || load_pending_q) begin
                    if (dirty_keep != '0) begin
                        state_d = FLUSH_REQ;
                        sec_d   = lowest_set(dirty_keep);
                    end else begin
                        start_load = 1'b1;
                    end
                end
            end
            FLUSH_REQ: begin
                if (ack_rise) state_d = FLUSH_XFER;
            end
            FLUSH_XFER: begin
                if (ack_fall) begin
                    dirty_d = dirty_left;
                    if (dirty_left != '0) begin
                        state_d = FLUSH_REQ;
                        sec_d   = lowest_set(dirty_left);
                    end else if (legal) begin
                        start_load = 1'b1;
                    end else begin
                        state_d       = IDLE;
                        track_valid_d = 1'b0;
                    end
                end
            end
            LOAD_REQ: begin
                if (ack_rise) state_d = LOAD_XFER;
            end
            LOAD_XFER: begin
                if (ack_fall) begin
                    if (load_pending_q || img_mounted || (track != load_track_q)) begin
                        if (legal) begin
                            start_load = 1'b1;
                        end else begin
                            // Buffer is half overwritten: forget which track it held.
                            state_d     = IDLE;
                            cur_track_d = '1;
                        end
                    end else if (sec_q == LAST_SEC) begin
                        state_d       = IDLE;
                        cur_track_d   = load_track_q;
                        track_valid_d = 1'b1;
                    end else begin
                        state_d = LOAD_REQ;
                        sec_d   = sec_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_load) begin
            state_d        = LOAD_REQ;
            sec_d          = '0;
            load_track_d   = track;
            track_valid_d  = 1'b0;
            load_pending_d = 1'b0;
        end

        // Outputs are registered from the next-state view so requests appear one cycle later.
        sd_rd_d    = (state_d == LOAD_REQ);
        sd_wr_d    = (state_d == FLUSH_REQ);
        cpu_wait_d = (state_d != IDLE);
        buf_sec_d  = sec_d;
        unique case (state_d)
            FLUSH_REQ, FLUSH_XFER: sd_lba_d = lba_of(cur_track_d, sec_d);
            LOAD_REQ, LOAD_XFER:   sd_lba_d = lba_of(load_track_d, sec_d);
            default:               sd_lba_d = sd_lba_q;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cur_track_q    <= 6'h3F;
            load_track_q   <= '0;
            dirty_q        <= '0;
            sec_q          <= '0;
            old_ack_q      <= 1'b0;
            load_pending_q <= 1'b0;
            track_valid_q  <= 1'b0;
            sd_rd_q        <= 1'b0;
            sd_wr_q        <= 1'b0;
            cpu_wait_q     <= 1'b0;
            sd_lba_q       <= '0;
            buf_sec_q      <= '0;
        end else begin
            state_q        <= state_d;
            cur_track_q    <= cur_track_d;
            load_track_q   <= load_track_d;
            dirty_q        <= dirty_d;
            sec_q          <= sec_d;
            old_ack_q      <= sd_ack;
            load_pending_q <= load_pending_d;
            track_valid_q  <= track_valid_d;
            sd_rd_q        <= sd_rd_d;
            sd_wr_q        <= sd_wr_d;
            cpu_wait_q     <= cpu_wait_d;
            sd_lba_q       <= sd_lba_d;
            buf_sec_q      <= buf_sec_d;
        end
    end

    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign buf_sec     = buf_sec_q;
    assign cpu_wait    = cpu_wait_q;
    assign track_valid = track_valid_q;

endmodule

// File: tb/tb_fdd_track_sched.sv
// Scoreboard bench for fdd_track_sched: a randomized SD host answers requests while a
// track/dirty-sector model predicts the ordered list of SD transfers.
module tb_fdd_track_sched;
    localparam int SPT       = 13;
    localparam int MAX_TRACK = 34;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [5:0]  track;
    logic        img_mounted, img_size_nz, img_readonly, wr_strobe;
    logic [3:0]  wr_sec;
    logic        sd_ack;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, cpu_wait, track_valid;
    logic [3:0]  buf_sec;

    always #5 clk_sys = ~clk_sys;

    fdd_track_sched #(.SPT(SPT), .MAX_TRACK(MAX_TRACK)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .track(track), .img_mounted(img_mounted),
        .img_size_nz(img_size_nz), .img_readonly(img_readonly), .wr_strobe(wr_strobe),
        .wr_sec(wr_sec), .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .buf_sec(buf_sec), .cpu_wait(cpu_wait), .track_valid(track_valid)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] lba;
        logic [3:0]  sec;
    } xfer_t;

    xfer_t       exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ack_cnt = 0;
    int          m_cur;
    logic [15:0] m_dirty;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_x(input logic wr, input int trk, input int s);
        xfer_t x;
        x.wr  = wr;
        x.lba = 32'(trk * SPT + s);
        x.sec = 4'(s);
        exp_q.push_back(x);
    endtask

    task automatic push_reads(input int trk, input int first, input int last);
        for (int s = first; s <= last; s++) push_x(1'b0, trk, s);
    endtask

    // SD host: random latency before ack, ack held for a random number of cycles.
    initial begin : sd_host
        int hstate;
        int hcnt;
        hstate = 0;
        hcnt   = 0;
        sd_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (!reset_n) begin
                sd_ack = 1'b0;
                hstate = 0;
            end else begin
                case (hstate)
                    0: if (sd_rd || sd_wr) begin
                        hcnt   = int'($urandom_range(0, 3));
                        hstate = 1;
                    end
                    1: if (hcnt == 0) begin
                        sd_ack = 1'b1;
                        ack_cnt++;
                        hcnt   = int'($urandom_range(1, 4));
                        hstate = 2;
                    end else begin
                        hcnt--;
                    end
                    default: begin
                        hcnt--;
                        if (hcnt == 0) begin
                            sd_ack = 1'b0;
                            hstate = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: every new request is popped from the scoreboard and compared.
    initial begin : monitor
        logic  prev_req;
        xfer_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                prev_req = 1'b0;
            end else begin
                if ((sd_rd || sd_wr) && !prev_req) begin
                    chk("rd_wr_exclusive", 32'(sd_rd & sd_wr), 32'd0);
                    chk("cpu_wait_busy", 32'(cpu_wait), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_request: got wr=%0d lba 0x%0h, required no request",
                                 sd_wr, sd_lba);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_kind_wr", 32'(sd_wr), 32'(e.wr));
                        chk("req_lba", sd_lba, e.lba);
                        chk("req_buf_sec", 32'(buf_sec), 32'(e.sec));
                    end
                end
                prev_req = sd_rd || sd_wr;
            end
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk_sys);
        while (cpu_wait && n < 4000) begin
            @(negedge clk_sys);
            n++;
        end
        chk({name, "_idle"}, 32'(cpu_wait), 32'd0);
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_track_valid"}, 32'(track_valid), 32'd1);
    endtask

    task automatic wait_acks(input int target);
        int n;
        n = 0;
        while (ack_cnt < target && n < 2000) begin
            @(posedge clk_sys);
            #2;
            n++;
        end
        chk("ack_wait", 32'(ack_cnt >= target), 32'd1);
    endtask

    task automatic wr_pulse(input int s, input logic ro, input logic mount);
        @(posedge clk_sys);
        #1;
        wr_strobe    = 1'b1;
        wr_sec       = 4'(s);
        img_readonly = ro;
        img_mounted  = mount;
        @(posedge clk_sys);
        #1;
        wr_strobe    = 1'b0;
        img_readonly = 1'b0;
        img_mounted  = 1'b0;
        if (mount) m_dirty = '0;
        else if (!ro && s < SPT) m_dirty[s] = 1'b1;
    endtask

    // Model of a track step: dirty sectors of the old track go out in ascending order,
    // then the whole new track is read.
    task automatic change_track(input int t, input string name);
        for (int s = 0; s < SPT; s++) if (m_dirty[s]) push_x(1'b1, m_cur, s);
        push_reads(t, 0, SPT - 1);
        m_dirty = '0;
        m_cur   = t;
        @(posedge clk_sys);
        #1;
        track = 6'(t);
        wait_done(name);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached after %0d vectors", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        int t;
        int np;
        reset_n      = 1'b0;
        track        = 6'd0;
        img_mounted  = 1'b0;
        img_size_nz  = 1'b1;
        img_readonly = 1'b0;
        wr_strobe    = 1'b0;
        wr_sec       = 4'd0;
        m_cur        = 63;
        m_dirty      = '0;

        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_sd_rd", 32'(sd_rd), 32'd0);
        chk("rst_sd_wr", 32'(sd_wr), 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("rst_track_valid", 32'(track_valid), 32'd0);
        chk("rst_sd_lba", sd_lba, 32'd0);
        chk("rst_buf_sec", 32'(buf_sec), 32'd0);

        push_reads(0, 0, SPT - 1);
        m_cur = 0;
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        wait_done("boot_load");

        change_track(5, "step_0_to_5");

        change_track(3, "step_to_3");
        wr_pulse(2, 1'b0, 1'b0);
        wr_pulse(7, 1'b0, 1'b0);
        wr_pulse(2, 1'b0, 1'b0);
        change_track(4, "flush_3_load_4");

        wr_pulse(1, 1'b1, 1'b0);
        wr_pulse(14, 1'b0, 1'b0);
        wr_pulse(15, 1'b0, 1'b0);
        change_track(9, "readonly_step");

        // Mount in idle with a write in the same cycle: mask cleared, same track reloaded.
        wr_pulse(3, 1'b0, 1'b0);
        push_reads(m_cur, 0, SPT - 1);
        wr_pulse(4, 1'b0, 1'b1);
        wait_done("mount_reload");

        // Step 1 -> 2 while sector 5 of track 1 is being read.
        base = ack_cnt;
        push_reads(1, 0, 5);
        push_reads(2, 0, SPT - 1);
        @(posedge clk_sys);
        #1;
        track = 6'd1;
        wait_acks(base + 6);
        track = 6'd2;
        m_cur = 2;
        wait_done("midload_step");
        wr_pulse(0, 1'b0, 1'b0);
        change_track(3, "flush_after_midload");

        // Mount while sector 2 of track 10 is in flight.
        base = ack_cnt;
        push_reads(10, 0, 2);
        push_reads(10, 0, SPT - 1);
        @(posedge clk_sys);
        #1;
        track = 6'd10;
        wait_acks(base + 3);
        img_mounted = 1'b1;
        @(posedge clk_sys);
        #1;
        img_mounted = 1'b0;
        m_cur = 10;
        wait_done("midload_mount");

        // Illegal track and empty image: stay idle, buffer invalid.
        @(posedge clk_sys);
        #1;
        track = 6'(MAX_TRACK + 1);
        repeat (5) @(negedge clk_sys);
        chk("bad_track_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("bad_track_valid", 32'(track_valid), 32'd0);
        @(posedge clk_sys);
        #1;
        track       = 6'd20;
        img_size_nz = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("no_image_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("no_image_valid", 32'(track_valid), 32'd0);
        push_reads(20, 0, SPT - 1);
        m_cur = 20;
        @(posedge clk_sys);
        #1;
        img_size_nz = 1'b1;
        wait_done("image_back");

        // Reset while sd_ack is high during the load of track 7.
        base = ack_cnt;
        push_reads(7, 0, 3);
        @(posedge clk_sys);
        #1;
        track = 6'd7;
        wait_acks(base + 4);
        chk("pre_reset_ack", 32'(sd_ack), 32'd1);
        chk("pre_reset_rd", 32'(sd_rd), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_sd_rd", 32'(sd_rd), 32'd0);
        chk("mid_reset_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("mid_reset_sd_lba", sd_lba, 32'd0);
        chk("mid_reset_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        m_dirty = '0;
        push_reads(7, 0, SPT - 1);
        m_cur = 7;
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        wait_done("reload_after_reset");

        for (int it = 0; it < 8; it++) begin
            np = int'($urandom_range(0, 4));
            for (int k = 0; k < np; k++) begin
                wr_pulse(int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), 1'b0);
            end
            t = int'($urandom_range(0, MAX_TRACK));
            if (t == m_cur) t = (t + 1) % (MAX_TRACK + 1);
            change_track(t, "random_step");
        end

        repeat (20) @(negedge clk_sys);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
